// File: rtl/adder_tb_pkg.sv
// Shared types and constants for the adder stimulus/checker block.
package adder_tb_pkg;

  localparam int OP_W        = 32;
  localparam int RESULT_W    = 40;
  localparam int DUT_LATENCY = 2;

  // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [OP_W-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [RESULT_W-1:0] expected;
  } pipe_t;

  function automatic logic [OP_W-1:0] lfsr_step(input logic [OP_W-1:0] v);
    logic [OP_W-1:0] shifted;
    shifted = v >> 1;
    if (v[0]) begin
      lfsr_step = shifted ^ LFSR_TAPS;
    end else begin
      lfsr_step = shifted;
    end
  endfunction

  function automatic logic [RESULT_W-1:0] expected_sum(input logic [OP_W-1:0] a,
                                                       input logic [OP_W-1:0] b);
    logic [OP_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    expected_sum = {7'b0000000, sum};
  endfunction

endpackage

// File: rtl/adder_stimulus_checker_if.sv
// Operand/result bus between the stimulus checker and the adder datapath.
interface adder_stimulus_checker_if;
  import adder_tb_pkg::*;

  logic [OP_W-1:0]     A;
  logic [OP_W-1:0]     B;
  logic                Sel;
  logic [RESULT_W-1:0] Result;

  modport master (output A, output B, output Sel, input Result);
  modport slave  (input A, input B, input Sel, output Result);

endinterface

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with seed load, advance enable and zero-seed substitution.
module lfsr32
  import adder_tb_pkg::*;
(
  input  logic            clk,
  input  logic            nRST,
  input  logic            load_i,
  input  logic [OP_W-1:0] seed_i,
  input  logic            en_i,
  output logic [OP_W-1:0] next_o
);

  logic [OP_W-1:0] lfsr_q;
  logic [OP_W-1:0] lfsr_d;
  logic [OP_W-1:0] seed_s;

  // A load already yields the first step so the caller can drive it the same cycle.
  always_comb begin
    seed_s = seed_i;
    lfsr_d = lfsr_q;
    if (seed_i == 32'h0000_0000) begin
      seed_s = 32'h0000_0001;
    end else begin
      seed_s = seed_i;
    end
    if (load_i) begin
      lfsr_d = lfsr_step(seed_s);
    end else if (en_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register
  always_ff @(posedge clk) begin
    if (!nRST) begin
      lfsr_q <= 32'h0000_0001;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign next_o = lfsr_d;

endmodule

// File: rtl/adder_stimulus_checker.sv
// Drives LFSR operand pairs into an adder datapath and counts mismatching sums
// that return DUT_LATENCY cycles later.
module adder_stimulus_checker
  import adder_tb_pkg::*;
#(
  parameter int NUM_W = 16
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  start,
  input  logic [NUM_W-1:0]      num_vectors,
  input  logic [OP_W-1:0]       seed,
  input  logic                  sel_mode,
  adder_stimulus_checker_if.master dut_bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [NUM_W-1:0]      err_count
);

  localparam logic [NUM_W-1:0] CNT_ONE  = {{(NUM_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_W-1:0] CNT_ZERO = {NUM_W{1'b0}};
  localparam logic [NUM_W-1:0] CNT_MAX  = {NUM_W{1'b1}};

  state_e          state_q;
  logic [NUM_W-1:0] vec_cnt_q;
  logic            drain_cnt_q;
  logic [NUM_W-1:0] err_q;
  logic [NUM_W-1:0] err_d;
  logic [OP_W-1:0] a_q;
  logic [OP_W-1:0] b_q;
  logic            sel_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  pipe_t           pipe_q [DUT_LATENCY];

  logic            accept_s;
  logic            launch_s;
  logic            run_s;
  logic            mismatch_s;
  logic [OP_W-1:0] lfsr_a_s;
  logic [OP_W-1:0] lfsr_b_s;

  assign accept_s   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign launch_s   = accept_s && (num_vectors != CNT_ZERO);
  assign run_s      = (state_q == ST_RUN);
  assign mismatch_s = pipe_q[DUT_LATENCY-1].valid &&
                      (dut_bus.Result != pipe_q[DUT_LATENCY-1].expected);

  lfsr32 u_lfsr_a (
    .clk    (clk),
    .nRST   (nRST),
    .load_i (launch_s),
    .seed_i (seed),
    .en_i   (run_s),
    .next_o (lfsr_a_s)
  );

  lfsr32 u_lfsr_b (
    .clk    (clk),
    .nRST   (nRST),
    .load_i (launch_s),
    .seed_i (~seed),
    .en_i   (run_s),
    .next_o (lfsr_b_s)
  );

  // Saturating error counter, cleared on every accepted start
  always_comb begin
    err_d = err_q;
    if (accept_s) begin
      err_d = CNT_ZERO;
    end else if (mismatch_s && (err_q != CNT_MAX)) begin
      err_d = err_q + CNT_ONE;
    end else begin
      err_d = err_q;
    end
  end

  // Expected-value pipeline aligned with the adder latency
  always_ff @(posedge clk) begin
    if (!nRST) begin
      for (int i = 0; i < DUT_LATENCY; i++) begin
        pipe_q[i] <= {($bits(pipe_t)){1'b0}};
      end
    end else begin
      pipe_q[0] <= '{valid: run_s, expected: expected_sum(a_q, b_q)};
      for (int i = 1; i < DUT_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Run-control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      vec_cnt_q   <= CNT_ZERO;
      drain_cnt_q <= 1'b0;
      err_q       <= CNT_ZERO;
      a_q         <= 32'h0000_0000;
      b_q         <= 32'h0000_0000;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (launch_s) begin
            state_q   <= ST_RUN;
            vec_cnt_q <= num_vectors;
            a_q       <= lfsr_a_s;
            b_q       <= lfsr_b_s;
            sel_q     <= sel_mode;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
          end else if (accept_s) begin
            state_q <= ST_DONE;
            a_q     <= 32'h0000_0000;
            b_q     <= 32'h0000_0000;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else begin
            state_q <= state_q;
          end
        end
        ST_RUN: begin
          sel_q <= sel_mode;
          if (vec_cnt_q == CNT_ONE) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= 1'b0;
            a_q         <= 32'h0000_0000;
            b_q         <= 32'h0000_0000;
          end else begin
            vec_cnt_q <= vec_cnt_q - CNT_ONE;
            a_q       <= lfsr_a_s;
            b_q       <= lfsr_b_s;
          end
        end
        ST_DRAIN: begin
          // The final compare lands on the last DRAIN edge, so pass uses err_d.
          if (drain_cnt_q) begin
            state_q <= ST_DONE;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == CNT_ZERO);
          end else begin
            drain_cnt_q <= 1'b1;
            sel_q       <= sel_mode;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          a_q     <= 32'h0000_0000;
          b_q     <= 32'h0000_0000;
          sel_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dut_bus.A   = a_q;
  assign dut_bus.B   = b_q;
  assign dut_bus.Sel = sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_adder_stimulus_checker.sv
// Directed bench: ideal/faulty 2-cycle adder models around the stimulus checker.
module tb_adder_stimulus_checker;
  import adder_tb_pkg::*;

  logic        clk;
  logic        nRST;
  logic        start;
  logic [15:0] num_vectors;
  logic [31:0] seed;
  logic        sel_mode;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic        fault;
  logic [39:0] stage_r;
  int          total;
  int          bad;
  int          cyc;
  logic        zero_seen;

  adder_stimulus_checker_if bus ();

  adder_stimulus_checker #(.NUM_W(16)) dut (
    .clk         (clk),
    .nRST        (nRST),
    .start       (start),
    .num_vectors (num_vectors),
    .seed        (seed),
    .sel_mode    (sel_mode),
    .dut_bus     (bus),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-register adder model; fault adds one to every sum
  always @(posedge clk) begin
    stage_r    <= {7'b0000000, ({1'b0, bus.A} + {1'b0, bus.B})} + {39'b0, fault};
    bus.Result <= stage_r;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_run(input logic [15:0] n, input logic [31:0] s, input logic sm);
    num_vectors = n;
    seed        = s;
    sel_mode    = sm;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    while (!done && cyc < 200) begin
      tick();
    end
    check(tag, 64'(cyc), 64'(exp_cyc));
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    cyc         = 0;
    fault       = 1'b0;
    nRST        = 1'b0;
    start       = 1'b0;
    num_vectors = 16'd0;
    seed        = 32'h0;
    sel_mode    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nRST = 1'b1;

    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset pass", 64'(pass), 64'd0);
    check("reset err", 64'(err_count), 64'd0);
    check("reset A", 64'(bus.A), 64'd0);
    check("reset Sel", 64'(bus.Sel), 64'd0);

    // Ideal adder, 4 vectors
    start_run(16'd4, 32'h1234_5678, 1'b0);
    check("ideal first A", 64'(bus.A), 64'h091A_2B3C);
    check("ideal first B", 64'(bus.B), 64'hF6C5_D4C0);
    check("ideal busy", 64'(busy), 64'd1);
    wait_done("ideal done cycle", 7);
    check("ideal err", 64'(err_count), 64'd0);
    check("ideal pass", 64'(pass), 64'd1);
    check("ideal A idle", 64'(bus.A), 64'd0);

    // Faulty adder, 8 vectors, Sel high
    fault = 1'b1;
    start_run(16'd8, 32'hCAFE_F00D, 1'b1);
    check("faulty Sel run", 64'(bus.Sel), 64'd1);
    wait_done("faulty done cycle", 11);
    check("faulty err", 64'(err_count), 64'd8);
    check("faulty pass", 64'(pass), 64'd0);
    check("faulty Sel done", 64'(bus.Sel), 64'd0);
    fault = 1'b0;

    // New run from DONE clears errors; start in DRAIN and on DONE entry ignored
    start_run(16'd3, 32'h0BAD_BEEF, 1'b0);
    check("restart err cleared", 64'(err_count), 64'd0);
    tick(); tick(); tick();
    check("drain busy", 64'(busy), 64'd1);
    start = 1'b1;
    tick();
    check("drain start ignored", 64'(busy), 64'd1);
    tick();
    start = 1'b0;
    check("drain end done", 64'(done), 64'd1);
    check("drain end cycle", 64'(cyc), 64'd6);
    check("drain end pass", 64'(pass), 64'd1);
    tick();
    check("done entry start ignored", 64'(busy), 64'd0);

    // Zero vectors
    start_run(16'd0, 32'h5555_AAAA, 1'b1);
    check("zero done", 64'(done), 64'd1);
    check("zero pass", 64'(pass), 64'd1);
    check("zero A", 64'(bus.A), 64'd0);
    check("zero B", 64'(bus.B), 64'd0);
    check("zero busy", 64'(busy), 64'd0);

    // Zero seed substitution, no lock-up over 16 vectors
    start_run(16'd16, 32'h0000_0000, 1'b0);
    check("seed0 first A", 64'(bus.A), 64'h8020_0003);
    check("seed0 first B", 64'(bus.B), 64'hFFDF_FFFC);
    zero_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (bus.A == 32'h0 || bus.B == 32'h0) zero_seen = 1'b1;
      tick();
    end
    check("seed0 no lockup", 64'(zero_seen), 64'd0);
    wait_done("seed0 done cycle", 19);
    check("seed0 err", 64'(err_count), 64'd0);

    // Reset in RUN cycle 3 of 10 with a faulty adder
    fault = 1'b1;
    start_run(16'd10, 32'h1357_9BDF, 1'b1);
    tick(); tick();
    nRST = 1'b0;
    tick();
    nRST  = 1'b1;
    fault = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort A", 64'(bus.A), 64'd0);
    check("abort B", 64'(bus.B), 64'd0);
    check("abort Sel", 64'(bus.Sel), 64'd0);
    tick(); tick();
    check("abort no pending err", 64'(err_count), 64'd0);
    start_run(16'd5, 32'h2468_ACE0, 1'b0);
    wait_done("fresh done cycle", 8);
    check("fresh err", 64'(err_count), 64'd0);
    check("fresh pass", 64'(pass), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
